muldiv_unit: RTL

- Parametrised, self-contained multi-cycle multiply/divide engine for the EX stage. Replaces the ad-hoc mult/div sequencing embedded in the ALU.
- Latches its operands on an explicit start handshake and runs a FSM with fixed, parameter-defined latency.
- Produces a HI/LO result pair and supports pipeline flush.
- The ALU drives start/op from decoded MULT/MULTU/DIV/DIVU and stalls the pipeline on busy.

---
 rtl/muldiv_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide engine for the EX stage: MULT/MULTU/DIV/DIVU with fixed
// latency, a registered HI/LO result pair, divide-by-zero short-circuit and pipeline flush.
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_mag_q, b_mag_q, rem_q;
  logic             neg_q, rem_neg_q;
  logic             done_q, div_zero_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  // Operand preparation: signed ops are reduced to magnitudes at acceptance.
  logic             idle, accept, is_signed, a_neg, b_neg, dz_in;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;

  assign idle      = (state_q == S_IDLE);
  assign accept    = start && !flush && idle;
  assign is_signed = ~op[0];
  assign a_neg     = is_signed & a[WIDTH-1];
  assign b_neg     = is_signed & b[WIDTH-1];
  assign a_mag_in  = a_neg ? -a : a;
  assign b_mag_in  = b_neg ? -b : b;
  assign dz_in     = op[1] && (b == '0);

  // In IDLE the core works on the incoming operands so the accept edge already does
  // one divide step (and a whole multiply when MUL_LAT is 1).
  logic [WIDTH-1:0] op_a, op_b, op_rem;
  logic             op_neg, op_rem_neg, cur_is_div;

  assign op_a       = idle ? a_mag_in : a_mag_q;
  assign op_b       = idle ? b_mag_in : b_mag_q;
  assign op_rem     = idle ? '0 : rem_q;
  assign op_neg     = idle ? (a_neg ^ b_neg) : neg_q;
  assign op_rem_neg = idle ? a_neg : rem_neg_q;
  assign cur_is_div = idle ? op[1] : (state_q == S_DIV);

  logic [2*WIDTH-1:0] product, prod_fix;
  logic [WIDTH:0]     shifted;
  logic               ge;
  logic [WIDTH-1:0]   rem_step, quo_step, rem_fix, quo_fix;

  assign product  = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
  assign prod_fix = op_neg ? -product : product;

  // One restoring-division step: the dividend magnitude shifts out of op_a while
  // quotient bits shift in at the bottom.
  assign shifted  = {op_rem, op_a[WIDTH-1]};
  assign ge       = shifted >= {1'b0, op_b};
  assign rem_step = ge ? WIDTH'(shifted - {1'b0, op_b}) : shifted[WIDTH-1:0];
  assign quo_step = {op_a[WIDTH-2:0], ge};
  assign quo_fix  = op_neg ? -quo_step : quo_step;
  assign rem_fix  = op_rem_neg ? -rem_step : rem_step;

  logic [CW-1:0] last_cnt;
  logic          commit_now, finish, commit;

  assign last_cnt   = cur_is_div ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
  assign commit_now = accept && (dz_in || (last_cnt == '0));
  assign finish     = !idle && !flush && (cnt_q == last_cnt);
  assign commit     = commit_now || finish;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every combinational process assigns its outputs a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:       if (accept && !commit_now) state_d = op[1] ? S_DIV : S_MUL;
      S_MUL, S_DIV: if (flush || finish) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      a_mag_q    <= '0;
      b_mag_q    <= '0;
      rem_q      <= '0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q <= commit;
      if (accept) begin
        a_mag_q    <= op[1] ? quo_step : a_mag_in;
        b_mag_q    <= b_mag_in;
        rem_q      <= op[1] ? rem_step : '0;
        neg_q      <= a_neg ^ b_neg;
        rem_neg_q  <= a_neg;
        cnt_q      <= CW'(1);
        div_zero_q <= 1'b0;
      end else if (state_q == S_DIV) begin
        a_mag_q <= quo_step;
        rem_q   <= rem_step;
        cnt_q   <= cnt_q + CW'(1);
      end else if (state_q == S_MUL) begin
        cnt_q <= cnt_q + CW'(1);
      end
      // Later assignment wins, so a divide-by-zero accept sets the flag it just cleared.
      if (commit) begin
        if (idle && dz_in) begin
          hi_q       <= a;
          lo_q       <= '1;
          div_zero_q <= 1'b1;
        end else if (cur_is_div) begin
          hi_q <= rem_fix;
          lo_q <= quo_fix;
        end else begin
          {hi_q, lo_q} <= prod_fix;
        end
      end
    end
  end

  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule
